// File: rtl/main_scu_bac_arbiter.sv
// Round-robin arbiter sharing one BAC register-bus port among p_num_req requesters,
// one outstanding transfer at a time, with a per-transfer wait timeout.
module main_scu_bac_arbiter #(
  parameter int p_num_req                      = 2,
  parameter int p_bac_reg_offset_address_width = 12,
  parameter int p_response_width               = 2,
  parameter int p_timeout                      = 255
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic [p_num_req-1:0]                                req_bac_csb_i,
  input  logic [p_num_req-1:0]                                req_bac_wr_i,
  input  logic [p_num_req*p_bac_reg_offset_address_width-1:0] req_bac_address_i,
  input  logic [p_num_req*32-1:0]                             req_bac_write_data_i,
  input  logic [p_num_req*4-1:0]                              req_bac_byte_en_i,
  output logic [p_num_req*32-1:0]                             req_bac_read_data_o,
  output logic [p_num_req-1:0]                                req_bac_ready_o,
  output logic [p_num_req*p_response_width-1:0]               req_bac_response_o,
  output logic                                                bac_csb_o,
  output logic                                                bac_wr_o,
  output logic [p_bac_reg_offset_address_width-1:0]           bac_address_o,
  output logic [31:0]                                         bac_write_data_o,
  output logic [3:0]                                          bac_byte_en_o,
  input  logic [31:0]                                         bac_read_data_i,
  input  logic                                                bac_ready_i,
  input  logic [p_response_width-1:0]                         bac_response_i,
  output logic [p_num_req-1:0]                                grant_o,
  output logic                                                timeout_o
);
  localparam int N  = p_num_req;
  localparam int AW = p_bac_reg_offset_address_width;
  localparam int RW = p_response_width;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (p_timeout > 1) ? $clog2(p_timeout + 1) : 1;
  localparam logic [RW-1:0] ErrResp = RW'(2'b10);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, gidx_q, gidx_d, pick_s;
  logic              found_s;
  logic [N-1:0]      grant_q, grant_d, ready_q, ready_d;
  logic              csb_q, csb_d, wr_q, wr_d, timeout_q, timeout_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [N*32-1:0]   rdata_q, rdata_d;
  logic [N*RW-1:0]   resp_q, resp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Index base+k wrapped into 0..N-1 (k < N, so one subtraction suffices).
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= 32'(N)) s = s - 32'(N);
    else             s = s;
    return PW'(s);
  endfunction

  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int unsigned k = 0; k < 32'(N); k++) begin
      if (!found_s && !req_bac_csb_i[rr_idx(ptr_q, k)]) begin
        found_s = 1'b1;
        pick_s  = rr_idx(ptr_q, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    ready_d   = ready_q;
    csb_d     = csb_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_ISSUE;
          gidx_d  = pick_s;
          grant_d = N'(1) << pick_s;
          csb_d   = 1'b0;
          wr_d    = req_bac_wr_i[pick_s];
          addr_d  = req_bac_address_i[pick_s*AW +: AW];
          wdata_d = req_bac_write_data_i[pick_s*32 +: 32];
          be_d    = req_bac_byte_en_i[pick_s*4 +: 4];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A ready in the final wait cycle still completes normally.
        if (bac_ready_i) begin
          csb_d                     = 1'b1;
          ready_d[gidx_q]           = 1'b1;
          rdata_d[gidx_q*32 +: 32]  = bac_read_data_i;
          resp_d[gidx_q*RW +: RW]   = bac_response_i;
          state_d                   = ST_DONE;
        end else if (cnt_q >= CW'(p_timeout - 1)) begin
          csb_d                     = 1'b1;
          ready_d[gidx_q]           = 1'b1;
          rdata_d[gidx_q*32 +: 32]  = 32'h0000_0000;
          resp_d[gidx_q*RW +: RW]   = ErrResp;
          timeout_d                 = 1'b1;
          state_d                   = ST_DONE;
        end else if (cnt_q != CW'(p_timeout)) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        ptr_d     = rr_idx(gidx_q, 32'd1);
        grant_d   = '0;
        ready_d   = '0;
        rdata_d   = '0;
        resp_d    = '0;
        timeout_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        csb_d   = 1'b1;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      ready_q   <= '0;
      csb_q     <= 1'b1;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      be_q      <= 4'h0;
      rdata_q   <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      csb_q     <= csb_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_bac_read_data_o = rdata_q;
  assign req_bac_ready_o     = ready_q;
  assign req_bac_response_o  = resp_q;
  assign bac_csb_o           = csb_q;
  assign bac_wr_o            = wr_q;
  assign bac_address_o       = addr_q;
  assign bac_write_data_o    = wdata_q;
  assign bac_byte_en_o       = be_q;
  assign grant_o             = grant_q;
  assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_main_scu_bac_arbiter.sv
// Bench for main_scu_bac_arbiter: directed steps plus random transfers checked
// against a transaction-level round-robin model.
module tb_main_scu_bac_arbiter;
  localparam int N  = 2;
  localparam int AW = 12;
  localparam int RW = 2;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_csb, req_wr, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*32-1:0]   req_wdata, req_rdata;
  logic [N*4-1:0]    req_be;
  logic [N*RW-1:0]   req_resp;
  logic              bac_csb, bac_wr, bac_ready, timeout;
  logic [AW-1:0]     bac_addr;
  logic [31:0]       bac_wdata, bac_rdata;
  logic [3:0]        bac_be;
  logic [RW-1:0]     bac_resp;
  logic [N-1:0]      grant;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;

  always #5 clk = ~clk;

  main_scu_bac_arbiter #(
    .p_num_req(N), .p_bac_reg_offset_address_width(AW),
    .p_response_width(RW), .p_timeout(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_bac_csb_i(req_csb), .req_bac_wr_i(req_wr), .req_bac_address_i(req_addr),
    .req_bac_write_data_i(req_wdata), .req_bac_byte_en_i(req_be),
    .req_bac_read_data_o(req_rdata), .req_bac_ready_o(req_ready),
    .req_bac_response_o(req_resp),
    .bac_csb_o(bac_csb), .bac_wr_o(bac_wr), .bac_address_o(bac_addr),
    .bac_write_data_o(bac_wdata), .bac_byte_en_o(bac_be),
    .bac_read_data_i(bac_rdata), .bac_ready_i(bac_ready), .bac_response_i(bac_resp),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first low csb starting at the model pointer.
  function automatic int pick_m(input logic [N-1:0] csb);
    for (int k = 0; k < N; k++)
      if (!csb[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return 0;
  endfunction

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      req_wr[i]              = 1'($urandom);
      req_addr[i*AW +: AW]   = AW'($urandom);
      req_wdata[i*32 +: 32]  = $urandom;
      req_be[i*4 +: 4]       = 4'($urandom);
    end
  endtask

  // One full transfer starting in IDLE; delay = WAIT cycle carrying bac_ready (<=0: never).
  task automatic do_xfer(input logic [N-1:0] mask, input int delay, input logic [31:0] rd,
                         input logic [RW-1:0] rs, input bit drop, input bit late);
    int w, n;
    bit to;
    logic ewr;
    logic [AW-1:0] ea;
    logic [31:0] ed;
    logic [3:0] eb;
    logic [N*32-1:0] erd;
    logic [N*RW-1:0] ers;
    chk("idle_csb", 64'(bac_csb), 64'd1);
    chk("idle_grant", 64'(grant), 64'd0);
    req_csb = mask;
    w   = pick_m(mask);
    ewr = req_wr[w];
    ea  = req_addr[w*AW +: AW];
    ed  = req_wdata[w*32 +: 32];
    eb  = req_be[w*4 +: 4];
    tick();
    chk("issue_grant", 64'(grant), 64'(N'(1) << w));
    chk("issue_csb", 64'(bac_csb), 64'd0);
    chk("issue_wr", 64'(bac_wr), 64'(ewr));
    chk("issue_addr", 64'(bac_addr), 64'(ea));
    chk("issue_wdata", 64'(bac_wdata), 64'(ed));
    chk("issue_be", 64'(bac_be), 64'(eb));
    scramble();
    if (drop) req_csb = '1;
    n = 0;
    do begin
      tick();
      n++;
      chk("wait_csb", 64'(bac_csb), 64'd0);
      chk("wait_ready", 64'(req_ready), 64'd0);
      chk("wait_addr", 64'(bac_addr), 64'(ea));
      chk("wait_timeout", 64'(timeout), 64'd0);
      bac_ready = (n == delay);
      bac_rdata = rd;
      bac_resp  = rs;
    end while (n != delay && n != TO);
    to = (n != delay);
    tick();
    bac_ready = late;
    bac_rdata = $urandom;
    erd = '0;
    ers = '0;
    erd[w*32 +: 32] = to ? 32'h0 : rd;
    ers[w*RW +: RW] = to ? RW'(2'b10) : rs;
    chk("done_ready", 64'(req_ready), 64'(N'(1) << w));
    chk("done_rdata", 64'(req_rdata), 64'(erd));
    chk("done_resp", 64'(req_resp), 64'(ers));
    chk("done_timeout", 64'(timeout), 64'(to));
    chk("done_csb", 64'(bac_csb), 64'd1);
    ptr_m = (w + 1) % N;
    tick();
    bac_ready = 1'b0;
    chk("post_ready", 64'(req_ready), 64'd0);
    chk("post_grant", 64'(grant), 64'd0);
    chk("post_timeout", 64'(timeout), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_csb = '1; req_wr = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    bac_ready = 1'b0; bac_rdata = 32'h0; bac_resp = '0;
    tick(); tick();
    chk("rst_csb", 64'(bac_csb), 64'd1);
    chk("rst_cmd", {bac_wr, bac_addr, bac_be}, 64'd0);
    chk("rst_wdata", 64'(bac_wdata), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rdata", 64'(req_rdata), 64'd0);
    chk("rst_resp", 64'(req_resp), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    rst = 1'b0;
    tick();

    // Write from requester 0, ready in second wait cycle.
    req_wr[0] = 1'b1; req_addr[0 +: AW] = 12'h00C; req_wdata[0 +: 32] = 32'h1; req_be[0 +: 4] = 4'hF;
    do_xfer(2'b10, 2, 32'h0, 2'b00, 1'b0, 1'b0);
    req_csb = '1;

    // Read from requester 1 returning DEADBEEF.
    req_wr[1] = 1'b0; req_addr[AW +: AW] = 12'h018;
    do_xfer(2'b01, 1, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0);
    req_csb = '1;

    // Both requesting continuously: four alternating grants.
    for (int i = 0; i < 4; i++) begin
      scramble();
      do_xfer(2'b00, 1 + i, $urandom, 2'($urandom), 1'b0, 1'b0);
    end

    // Timeout abort with a late ready in DONE, then the other requester.
    do_xfer(2'b00, 0, $urandom, 2'b00, 1'b0, 1'b1);
    do_xfer(2'b00, 3, $urandom, 2'b01, 1'b0, 1'b0);
    // Ready exactly on the last allowed wait cycle.
    do_xfer(2'b00, TO, 32'h1234_5678, 2'b00, 1'b0, 1'b0);
    req_csb = '1;

    // Reset during WAIT with pointer at requester 1.
    do_xfer(2'b10, 1, $urandom, 2'b00, 1'b0, 1'b0);
    req_csb = 2'b01;
    tick(); tick(); tick();
    rst = 1'b1;
    req_csb = '1;
    tick();
    chk("mrst_csb", 64'(bac_csb), 64'd1);
    chk("mrst_grant", 64'(grant), 64'd0);
    chk("mrst_ready", 64'(req_ready), 64'd0);
    chk("mrst_timeout", 64'(timeout), 64'd0);
    tick();
    chk("mrst_ready2", 64'(req_ready), 64'd0);
    rst = 1'b0;
    ptr_m = 0;
    tick();
    do_xfer(2'b00, 2, $urandom, 2'b11, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] m;
      scramble();
      m = N'($urandom_range(0, 2));
      do_xfer(m, $urandom_range(1, TO + 2), $urandom, RW'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom));
      if ($urandom_range(0, 1) == 0) req_csb = '1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
